// File: rtl/mar_burst.sv
// mar_burst: memory address register with a burst address generator.
// In IDLE, DMEM can be loaded directly from addr_in. A start command launches
// a burst of burst_len beats. Each mem_ack moves DMEM to the next address,
// either linearly or wrapping inside a 2^WRAP_LOG2 window. done pulses for one
// cycle after the final beat. err stays set once a linear burst has wrapped
// past the top of the address space.
//
// Handshake: while busy is high, DMEM is held stable and is treated as
// "valid". mem_ack acts as "ready": one beat is consumed on each rising edge
// where mem_ack=1. abort wins over mem_ack on the same edge. mem_ack and abort
// have no effect in IDLE.
module mar_burst #(
  parameter int ADDR_W    = 24,
  parameter int LEN_W     = 8,
  parameter int STRIDE    = 1,
  parameter int WRAP_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              mode,
  input  logic              mem_ack,
  input  logic              abort,
  output logic [ADDR_W-1:0] DMEM,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]    STRIDE_EXT = (ADDR_W+1)'(STRIDE);
  localparam logic [WRAP_LOG2-1:0] STRIDE_LO = WRAP_LOG2'(STRIDE);
  localparam logic [LEN_W-1:0]   LEN_ONE    = LEN_W'(1);
  localparam logic [LEN_W-1:0]   LEN_ZERO   = '0;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   dmem_q, dmem_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                mode_q, mode_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [ADDR_W:0]       lin_sum;
  logic [WRAP_LOG2-1:0]  wrap_low;
  logic [ADDR_W-1:0]     wrap_addr;
  logic                  last_beat;
  logic                  start_ok;

  // Address arithmetic and beat bookkeeping derived from the current registers
  always_comb begin
    lin_sum   = {1'b0, dmem_q} + STRIDE_EXT;
    wrap_low  = dmem_q[WRAP_LOG2-1:0] + STRIDE_LO;
    wrap_addr = {dmem_q[ADDR_W-1:WRAP_LOG2], wrap_low};
    // The counter only ever reaches len-1, so it never overflows even when len is at its maximum
    last_beat = (cnt_q == (len_q - LEN_ONE));
    start_ok  = start && (burst_len != LEN_ZERO);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a non-empty start enters RUN; the last acked beat or abort leaves it
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_RUN;
      end
      S_RUN: begin
        if (abort)                       state_d = S_IDLE;
        else if (mem_ack && last_beat)   state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: loads, burst setup, and per-beat address advance
  always_comb begin
    dmem_d = dmem_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    mode_d = mode_q;
    done_d = 1'b0;
    err_d  = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (start_ok) begin
            if (write) dmem_d = addr_in;
            len_d  = burst_len;
            mode_d = mode;
            cnt_d  = LEN_ZERO;
          end else begin
            // An empty burst completes at once and leaves DMEM alone
            done_d = 1'b1;
          end
        end else if (write) begin
          dmem_d = addr_in;
        end
      end
      S_RUN: begin
        if (abort) begin
          cnt_d = LEN_ZERO;
        end else if (mem_ack) begin
          if (last_beat) begin
            // The final address stays on DMEM after the burst finishes
            done_d = 1'b1;
            cnt_d  = LEN_ZERO;
          end else begin
            cnt_d = cnt_q + LEN_ONE;
            if (mode_q) begin
              dmem_d = wrap_addr;
            end else begin
              dmem_d = lin_sum[ADDR_W-1:0];
              if (lin_sum[ADDR_W]) err_d = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_q <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      dmem_q <= dmem_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      mode_q <= mode_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // Outputs: busy follows the RUN state; everything else comes straight from registers
  always_comb begin
    DMEM      = dmem_q;
    busy      = (state_q == S_RUN);
    done      = done_q;
    err       = err_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_mar_burst.sv
// Bench for mar_burst. Expected addresses come from closed-form formulas:
// base + k*STRIDE, either modulo the full address space or modulo the wrap window.
module tb_mar_burst;
  localparam int AW = 24;
  localparam int LW = 8;
  localparam int S  = 1;
  localparam int WL = 4;

  logic          clk = 1'b0;
  logic          rst, write, start, mode, mem_ack, abort;
  logic [AW-1:0] addr_in;
  logic [LW-1:0] burst_len;
  logic [AW-1:0] DMEM;
  logic          busy, done, err, dbg_state;

  mar_burst #(.ADDR_W(AW), .LEN_W(LW), .STRIDE(S), .WRAP_LOG2(WL)) dut (
    .clk(clk), .rst(rst), .write(write), .addr_in(addr_in), .start(start),
    .burst_len(burst_len), .mode(mode), .mem_ack(mem_ack), .abort(abort),
    .DMEM(DMEM), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: expected DMEM and sticky err while idle
  logic [AW-1:0] m_dmem;
  bit            m_err;
  logic [AW+2:0] got, want;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int k, input bit wm);
    longint        off;
    logic [AW-1:0] r;
    logic [WL-1:0] lo;
    off = longint'(k) * S;
    if (wm) begin
      lo = WL'((longint'(base[WL-1:0]) + off) % (64'd1 << WL));
      r  = {base[AW-1:WL], lo};
    end else begin
      r = AW'((longint'(base) + off) % (64'd1 << AW));
    end
    return r;
  endfunction

  // Runs one burst command and checks every cycle against the reference.
  // ack_pct < 0 acknowledges every other cycle; otherwise it is an ack probability in percent.
  task automatic run_burst(input string name, input logic [AW-1:0] addr, input int len,
                           input bit wm, input bit do_wr, input int ack_pct,
                           input int abort_at, input int rst_at, input bit post_idle);
    logic [AW-1:0] base;
    int k, cyc;
    bit fin, ack_now;
    base = do_wr ? addr : m_dmem;
    write = do_wr; addr_in = addr; start = 1'b1; burst_len = LW'(len); mode = wm;
    mem_ack = 1'b0; abort = 1'b0;
    tick();
    write = 1'b0; start = 1'b0;
    m_err = 1'b0;
    if (len == 0) begin
      want = {m_dmem, 1'b0, 1'b1, 1'b0};
    end else begin
      m_dmem = base;
      want = {base, 1'b1, 1'b0, 1'b0};
    end
    got = {DMEM, busy, done, err};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s start: got dmem/busy/done/err=%h want %h", name, got, want);
    end
    if (len > 0) begin
      k = 0; cyc = 0; fin = 1'b0;
      while (!fin && cyc < len * 10 + 100) begin
        cyc++;
        if (k == rst_at) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          m_dmem = '0; m_err = 1'b0;
          want = '0;
          fin = 1'b1;
        end else if (k == abort_at) begin
          abort = 1'b1; mem_ack = 1'b1;
          tick();
          abort = 1'b0; mem_ack = 1'b0;
          want = {m_dmem, 1'b0, 1'b0, m_err};
          fin = 1'b1;
        end else begin
          ack_now = (ack_pct < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < ack_pct);
          mem_ack = ack_now;
          // write/start noise must be ignored while the burst runs
          write = 1'($urandom); start = 1'($urandom); addr_in = AW'($urandom);
          tick();
          mem_ack = 1'b0; write = 1'b0; start = 1'b0;
          if (ack_now && k == len - 1) begin
            want = {m_dmem, 1'b0, 1'b1, m_err};
            fin = 1'b1;
          end else begin
            if (ack_now) begin
              k++;
              m_dmem = exp_addr(base, k, wm);
              if (!wm && (longint'(base) + longint'(k) * S >= (64'd1 << AW))) m_err = 1'b1;
            end
            want = {m_dmem, 1'b1, 1'b0, m_err};
          end
        end
        got = {DMEM, busy, done, err};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL %s beat %0d: got dmem/busy/done/err=%h want %h", name, k, got, want);
        end
      end
      if (!fin) begin
        total++; bad++;
        $display("FAIL %s timeout: got busy=%b want burst end within budget", name, busy);
      end
    end
    if (post_idle) begin
      tick();
      got = {DMEM, busy, done, err};
      want = {m_dmem, 1'b0, 1'b0, m_err};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s idle: got dmem/busy/done/err=%h want %h", name, got, want);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; write = 1'b0; start = 1'b0; mode = 1'b0; mem_ack = 1'b0; abort = 1'b0;
    addr_in = '0; burst_len = '0;
    tick(); tick();
    got = {DMEM, busy, done, err};
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL reset_held: got %h want %h", got, {(AW+3){1'b0}});
    end
    rst = 1'b0;
    tick();
    got = {DMEM, busy, done, err, dbg_state};
    total++;
    if (got !== '0 || dbg_state !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got %h state=%b want 0", got, dbg_state);
    end
    m_dmem = '0; m_err = 1'b0;
  endtask

  task automatic test_load();
    write = 1'b1; addr_in = 24'd100;
    tick();
    write = 1'b0; addr_in = 24'd55;
    total++;
    if (DMEM !== 24'd100 || busy !== 1'b0) begin
      bad++;
      $display("FAIL load_first: got dmem=%h busy=%b want %h busy=0", DMEM, busy, 24'd100);
    end
    // mem_ack and abort are ignored in IDLE
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'(i); abort = 1'(i >> 1);
      tick();
      total++;
      if (DMEM !== 24'd100 || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL load_hold %0d: got dmem=%h busy=%b done=%b want %h 0 0", i, DMEM, busy, done, 24'd100);
      end
    end
    mem_ack = 1'b0; abort = 1'b0;
    write = 1'b1; addr_in = 24'd32;
    tick();
    write = 1'b0;
    total++;
    if (DMEM !== 24'd32) begin
      bad++;
      $display("FAIL load_second: got dmem=%h want %h", DMEM, 24'd32);
    end
    m_dmem = 24'd32;
  endtask

  task automatic test_linear();
    run_burst("linear", 24'h000010, 4, 1'b0, 1'b1, 100, -1, -1, 1'b1);
  endtask

  task automatic test_wrap();
    run_burst("wrap", 24'h00003E, 4, 1'b1, 1'b1, -1, -1, -1, 1'b1);
  endtask

  task automatic test_overflow();
    run_burst("overflow", 24'hFFFFFE, 3, 1'b0, 1'b1, 100, -1, -1, 1'b1);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky: got err=%b want 1", err);
    end
    run_burst("after_overflow", 24'h000020, 2, 1'b0, 1'b1, 100, -1, -1, 1'b1);
  endtask

  task automatic test_abort();
    run_burst("abort", 24'h001230, 8, 1'b0, 1'b1, 100, 3, -1, 1'b1);
    run_burst("reset_mid", 24'h004440, 8, 1'b0, 1'b1, 100, -1, 2, 1'b1);
    run_burst("len0", 24'hABCDEF, 0, 1'b0, 1'b1, 100, -1, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_burst("b2b_a", 24'h000100, 3, 1'b0, 1'b1, 70, -1, -1, 1'b0);
    run_burst("b2b_b", 24'h0002FE, 5, 1'b1, 1'b1, 70, -1, -1, 1'b0);
    run_burst("b2b_c", 24'h000000, 4, 1'b0, 1'b0, 70, -1, -1, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_burst("rand", AW'($urandom), $urandom_range(16, 1), 1'($urandom), 1'($urandom),
                $urandom_range(100, 30), -1, -1, 1'($urandom));
    end
    run_burst("maxlen", 24'hFFFF80, 255, 1'b0, 1'b1, 100, -1, -1, 1'b1);
    run_burst("maxlen_wrap", 24'h123456, 255, 1'b1, 1'b1, 60, -1, -1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_load();
    test_linear();
    test_wrap();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
